// File: rtl/ifetch.sv
// Instruction fetch: PC, a single-outstanding req/gnt/rvalid memory port,
// and a valid/ready output register that feeds decode and the ALU.
module ifetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct7,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);

  // state  | meaning
  // S_REQ  | request fetch_pc when the output register can take a word
  // S_WAIT | one request in flight, its data will be kept
  // S_KILL | one request in flight on the wrong path, its data is dropped
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_KILL = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t          state_q;
  state_t          state_d;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_inc;
  logic [XLEN-1:0] redirect_pc;
  logic            load;
  logic            unused_target_bits;

  assign fetch_pc_inc       = fetch_pc + XLEN'(4);
  assign redirect_pc        = {PCTarget[XLEN-1:2], 2'b00};
  assign unused_target_bits = ^PCTarget[1:0];

  assign imem_addr = fetch_pc;
  assign op        = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[30];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        // a grant coinciding with a redirect leaves an old-path word in flight
        if (imem_req && imem_gnt) begin
          state_d = PCSrc ? S_KILL : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
        end else if (PCSrc) begin
          state_d = S_KILL;
        end
      end
      S_KILL: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    load     = 1'b0;
    case (state_q)
      S_REQ:   imem_req = !rst && (!instr_valid || instr_ready);
      S_WAIT:  load     = imem_rvalid && !PCSrc;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= NOP;
      pc          <= RESET_PC;
      pc_plus4    <= RESET_PC + XLEN'(4);
    end else if (PCSrc) begin
      fetch_pc    <= redirect_pc;
      instr_valid <= 1'b0;
    end else if (load) begin
      instr       <= imem_rdata;
      pc          <= fetch_pc;
      pc_plus4    <= fetch_pc_inc;
      instr_valid <= 1'b1;
      fetch_pc    <= fetch_pc_inc;
    end else if (instr_valid && instr_ready) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: a latency-programmable memory responder, a consume
// monitor, and per-scenario tasks comparing against a queue of expected words.
module tb_ifetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        PCSrc = 1'b0;
  logic [31:0] PCTarget = '0;
  logic        instr_ready = 1'b0;

  logic        imem_req, instr_valid, funct7;
  logic [31:0] imem_addr, instr, pc, pc_plus4;
  logic [6:0]  op;
  logic [2:0]  funct3;

  logic        w_imem_req, w_instr_valid, w_funct7;
  logic [31:0] w_imem_addr, w_instr, w_pc, w_pc_plus4;
  logic [6:0]  w_op;
  logic [2:0]  w_funct3;

  int          n_cmp = 0;
  int          n_err = 0;

  int          rsp_delay = 1;
  logic        pend = 1'b0;
  int          pcnt = 0;
  logic [31:0] paddr = '0;
  logic        force_en = 1'b0;
  logic [31:0] force_val = '0;
  logic        mon_en = 1'b0;

  logic [31:0] grant_q[$];
  exp_t        exp_q[$];
  obs_t        got_q[$];

  always #5 clk = ~clk;

  ifetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PCSrc(PCSrc), .PCTarget(PCTarget),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .op(op), .funct3(funct3), .funct7(funct7), .pc(pc), .pc_plus4(pc_plus4)
  );

  ifetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PCSrc(PCSrc), .PCTarget(PCTarget),
    .instr_valid(w_instr_valid), .instr_ready(instr_ready), .instr(w_instr),
    .op(w_op), .funct3(w_funct3), .funct7(w_funct7), .pc(w_pc), .pc_plus4(w_pc_plus4)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00A0_0113;
      default: return {a[24:0], 7'b0010011};
    endcase
  endfunction

  // memory model: records grants at negedge, answers rsp_delay cycles later
  initial begin
    forever begin
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (pend) begin
        pcnt = pcnt - 1;
        if (pcnt <= 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = force_en ? force_val : mem_word(paddr);
          pend        = 1'b0;
        end
      end
      @(negedge clk);
      if (!rst && imem_req && imem_gnt) begin
        pend  = 1'b1;
        paddr = imem_addr;
        pcnt  = rsp_delay;
        grant_q.push_back(imem_addr);
      end
    end
  end

  initial begin
    obs_t o;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && instr_valid && instr_ready) begin
        o.pc = pc; o.pcp4 = pc_plus4; o.instr = instr;
        o.op = op; o.f3 = funct3; o.f7 = funct7;
        got_q.push_back(o);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    at_neg();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %0b expected 0", imem_req); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b expected 0", instr_valid); end
    n_cmp++; if (instr !== 32'h0000_0013) begin n_err++; $display("FAIL rst_instr: got %h expected 00000013", instr); end
    n_cmp++; if (op !== 7'b0010011) begin n_err++; $display("FAIL rst_op: got %b expected 0010011", op); end
    n_cmp++; if (pc !== 32'h0 || pc_plus4 !== 32'h4) begin n_err++; $display("FAIL rst_pc: got %h/%h expected 0/4", pc, pc_plus4); end
    n_cmp++; if (w_pc !== 32'hFFFF_FFFC || w_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL rst_pc_w: got %h/%h expected fffffffc/0", w_pc, w_pc_plus4); end
  endtask

  task automatic test_seq();
    obs_t o; exp_t e; int i;
    exp_q.delete(); got_q.delete(); grant_q.delete();
    mon_en = 1'b1;
    exp_q.push_back('{pc: 32'h0, instr: 32'h0050_0093});
    exp_q.push_back('{pc: 32'h4, instr: 32'h00A0_0113});
    step();
    rst = 1'b0; imem_gnt = 1'b1; instr_ready = 1'b1; rsp_delay = 1;
    at_neg();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL seq_first_req: got %0b@%h expected 1@00000000", imem_req, imem_addr); end
    // stop after the second grant so the word at 0x4 sits under backpressure
    for (i = 0; i < 20; i++) begin
      step();
      if (grant_q.size() >= 2) begin
        imem_gnt = 1'b0; instr_ready = 1'b0;
        break;
      end
    end
    n_cmp++; if (grant_q.size() < 2) begin n_err++; $display("FAIL seq_grants: got %0d expected 2", grant_q.size()); end
    else begin
      n_cmp++; if (grant_q[0] !== 32'h0 || grant_q[1] !== 32'h4) begin n_err++; $display("FAIL seq_addrs: got %h,%h expected 0,4", grant_q[0], grant_q[1]); end
    end
    n_cmp++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin n_err++; $display("FAIL seq_word0: got none expected pc 0"); end
    else begin
      o = got_q.pop_front(); e = exp_q.pop_front();
      if ({o.pc, o.pcp4, o.instr, o.op, o.f3, o.f7} !== {e.pc, e.pc + 32'd4, e.instr, e.instr[6:0], e.instr[14:12], e.instr[30]}) begin
        n_err++; $display("FAIL seq_word0: got pc %h p4 %h instr %h expected pc %h instr %h", o.pc, o.pcp4, o.instr, e.pc, e.instr);
      end
      n_cmp++; if (o.op !== 7'b0010011 || o.f3 !== 3'd0) begin n_err++; $display("FAIL seq_fields: got %b/%0d expected 0010011/0", o.op, o.f3); end
    end
  endtask

  task automatic test_backpressure();
    rsp_delay = 3;
    step();
    for (int c = 0; c < 5; c++) begin
      at_neg();
      n_cmp++;
      if (instr_valid !== 1'b1 || instr !== 32'h00A0_0113 || pc !== 32'h4 || imem_req !== 1'b0 || imem_addr !== 32'h8) begin
        n_err++; $display("FAIL bp_hold[%0d]: got v%0b %h pc %h req %0b addr %h expected v1 00a00113 pc 4 req 0 addr 8", c, instr_valid, instr, pc, imem_req, imem_addr);
      end
      step();
    end
    instr_ready = 1'b1; imem_gnt = 1'b1;
    at_neg();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_err++; $display("FAIL bp_release: got %0b@%h expected 1@00000008", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    obs_t o; exp_t e;
    step();
    n_cmp++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin n_err++; $display("FAIL bp_word4: got none expected pc 4"); end
    else begin
      o = got_q.pop_front(); e = exp_q.pop_front();
      if ({o.pc, o.pcp4, o.instr} !== {e.pc, e.pc + 32'd4, e.instr}) begin
        n_err++; $display("FAIL bp_word4: got pc %h p4 %h instr %h expected pc %h instr %h", o.pc, o.pcp4, o.instr, e.pc, e.instr);
      end
    end
    PCSrc = 1'b1; PCTarget = 32'h103;
    exp_q.push_back('{pc: 32'h100, instr: mem_word(32'h100)});
    at_neg();
    step();
    PCSrc = 1'b0;
    at_neg();
    n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL rw_kill: got req %0b v %0b expected 0 0", imem_req, instr_valid); end
    step();
    at_neg();
    n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL rw_drop: got req %0b v %0b expected 0 0", imem_req, instr_valid); end
    step();
    at_neg();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin n_err++; $display("FAIL rw_target: got %0b@%h v %0b expected 1@00000100 v 0", imem_req, imem_addr, instr_valid); end
    step();
    imem_gnt = 1'b0;
    for (int i = 0; i < 20 && got_q.size() == 0; i++) step();
    n_cmp++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin n_err++; $display("FAIL rw_word: got none expected pc 100"); end
    else begin
      o = got_q.pop_front(); e = exp_q.pop_front();
      if ({o.pc, o.pcp4, o.instr, o.op} !== {e.pc, e.pc + 32'd4, e.instr, e.instr[6:0]}) begin
        n_err++; $display("FAIL rw_word: got pc %h p4 %h instr %h expected pc %h instr %h", o.pc, o.pcp4, o.instr, e.pc, e.instr);
      end
    end
    n_cmp++; if (grant_q.size() != 4) begin n_err++; $display("FAIL rw_grants: got %0d expected 4", grant_q.size()); end
    else if (grant_q[2] !== 32'h8 || grant_q[3] !== 32'h100) begin n_err++; $display("FAIL rw_grants: got %h,%h expected 8,100", grant_q[2], grant_q[3]); end
  endtask

  task automatic test_redirect_grant();
    obs_t o; exp_t e;
    rsp_delay = 2;
    PCSrc = 1'b1; PCTarget = 32'hC;
    at_neg();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin n_err++; $display("FAIL rg_park: got %0b@%h expected 1@00000104", imem_req, imem_addr); end
    step();
    PCSrc = 1'b0;
    at_neg();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'hC || instr_valid !== 1'b0) begin n_err++; $display("FAIL rg_noGnt: got %0b@%h v %0b expected 1@0000000c v 0", imem_req, imem_addr, instr_valid); end
    step();
    imem_gnt = 1'b1; PCSrc = 1'b1; PCTarget = 32'h40;
    exp_q.push_back('{pc: 32'h40, instr: mem_word(32'h40)});
    at_neg();
    step();
    PCSrc = 1'b0;
    at_neg();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rg_kill: got req %0b expected 0", imem_req); end
    step();
    at_neg();
    n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL rg_drop: got req %0b v %0b expected 0 0", imem_req, instr_valid); end
    step();
    at_neg();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0) begin n_err++; $display("FAIL rg_target: got %0b@%h v %0b expected 1@00000040 v 0", imem_req, imem_addr, instr_valid); end
    step();
    imem_gnt = 1'b0;
    for (int i = 0; i < 20 && got_q.size() == 0; i++) step();
    n_cmp++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin n_err++; $display("FAIL rg_word: got none expected pc 40"); end
    else begin
      o = got_q.pop_front(); e = exp_q.pop_front();
      if ({o.pc, o.pcp4, o.instr} !== {e.pc, e.pc + 32'd4, e.instr}) begin
        n_err++; $display("FAIL rg_word: got pc %h p4 %h instr %h expected pc %h instr %h", o.pc, o.pcp4, o.instr, e.pc, e.instr);
      end
    end
    n_cmp++; if (grant_q.size() != 6) begin n_err++; $display("FAIL rg_grants: got %0d expected 6", grant_q.size()); end
    else if (grant_q[4] !== 32'hC || grant_q[5] !== 32'h40) begin n_err++; $display("FAIL rg_grants: got %h,%h expected c,40", grant_q[4], grant_q[5]); end
  endtask

  task automatic test_back_to_back();
    obs_t o; exp_t e;
    PCSrc = 1'b1; PCTarget = 32'h200;
    step();
    PCTarget = 32'h300;
    step();
    PCSrc = 1'b0;
    exp_q.push_back('{pc: 32'h300, instr: mem_word(32'h300)});
    at_neg();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin n_err++; $display("FAIL b2b_target: got %0b@%h expected 1@00000300", imem_req, imem_addr); end
    step();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    for (int i = 0; i < 20 && got_q.size() == 0; i++) step();
    n_cmp++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin n_err++; $display("FAIL b2b_word: got none expected pc 300"); end
    else begin
      o = got_q.pop_front(); e = exp_q.pop_front();
      if ({o.pc, o.pcp4, o.instr} !== {e.pc, e.pc + 32'd4, e.instr}) begin
        n_err++; $display("FAIL b2b_word: got pc %h p4 %h instr %h expected pc %h instr %h", o.pc, o.pcp4, o.instr, e.pc, e.instr);
      end
    end
  endtask

  task automatic test_wrap();
    int i;
    mon_en = 1'b0;
    rst = 1'b1; imem_gnt = 1'b0; instr_ready = 1'b1;
    force_en = 1'b1; force_val = 32'h40B5_0533; rsp_delay = 1;
    repeat (2) step();
    rst = 1'b0; imem_gnt = 1'b1;
    at_neg();
    n_cmp++; if (w_imem_req !== 1'b1 || w_imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_req: got %0b@%h expected 1@fffffffc", w_imem_req, w_imem_addr); end
    for (i = 0; i < 10; i++) begin
      step();
      at_neg();
      if (w_instr_valid === 1'b1) break;
    end
    n_cmp++;
    if (w_instr_valid !== 1'b1) begin n_err++; $display("FAIL wrap_timeout: got valid %0b expected 1", w_instr_valid); end
    else begin
      n_cmp++; if (w_instr !== 32'h40B5_0533 || w_pc !== 32'hFFFF_FFFC || w_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc: got %h pc %h p4 %h expected 40b50533 fffffffc 0", w_instr, w_pc, w_pc_plus4); end
      n_cmp++; if (w_funct7 !== 1'b1 || w_op !== 7'b0110011 || w_funct3 !== 3'd0) begin n_err++; $display("FAIL wrap_slices: got f7 %0b op %b f3 %0d expected 1 0110011 0", w_funct7, w_op, w_funct3); end
      n_cmp++; if (w_imem_req !== 1'b1 || w_imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_next: got %0b@%h expected 1@00000000", w_imem_req, w_imem_addr); end
    end
  endtask

  task automatic test_reset_mid();
    step();
    imem_gnt = 1'b0; rst = 1'b1; force_en = 1'b0; rsp_delay = 4;
    repeat (3) step();
    rst = 1'b0; imem_gnt = 1'b1;
    at_neg();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL rm_req: got %0b@%h expected 1@00000000", imem_req, imem_addr); end
    step();
    imem_gnt = 1'b0;
    at_neg();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rm_wait: got req %0b expected 0", imem_req); end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    at_neg();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL rm_after: got %0b@%h v %0b expected 1@00000000 v 0", imem_req, imem_addr, instr_valid); end
    step();
    at_neg();
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rm_rvalid: got v %0b expected 0", instr_valid); end
    step();
    at_neg();
    n_cmp++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL rm_ignored: got v %0b req %0b@%h expected v 0 req 1@00000000", instr_valid, imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_backpressure();
    test_redirect_wait();
    test_redirect_grant();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog");
  end

endmodule
